// File: rtl/firebird7_in_gate1_tessent_tdr_pkg.sv
// Shared constants and helpers for the gate1 IJTAG TDR family.
// Optional feature macro: FIREBIRD7_IN_GATE1_TDR_PARITY_EN (adds a parity bit to the chain).
package firebird7_in_gate1_tessent_tdr_pkg;

    localparam int TDR_W19_WIDTH   = 19;
    // Select bit sits directly above the data field in the chain.
    localparam int TDR_W19_SEL_IDX = TDR_W19_WIDTH;
    // Widest {select, data} vector the parity helper accepts.
    localparam int TDR_PAR_MAX_W   = 64;

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    localparam bit TDR_PARITY_EN = 1'b1;
`else
    localparam bit TDR_PARITY_EN = 1'b0;
`endif

    // Per-cycle action once sel and the enable priority are resolved.
    typedef enum logic [1:0] {
        TDR_OP_IDLE    = 2'd0,
        TDR_OP_CAPTURE = 2'd1,
        TDR_OP_SHIFT   = 2'd2,
        TDR_OP_UPDATE  = 2'd3
    } tdr_op_e;

    // Chain length: data + select, plus one parity bit when enabled.
    function automatic int tdr_chain_len(input int width, input bit parity_en);
        return width + 1 + (parity_en ? 1 : 0);
    endfunction

    // Parity bit that makes the XOR of the covered bits plus itself zero.
    function automatic logic tdr_even_parity(input logic [TDR_PAR_MAX_W-1:0] vec);
        return ^vec;
    endfunction

    // Enable priority ce > se > ue, all qualified by sel.
    function automatic tdr_op_e tdr_decode(input logic sel, input logic ce,
                                           input logic se, input logic ue);
        tdr_op_e op;
        op = TDR_OP_IDLE;
        if (sel) begin
            if (ce)      op = TDR_OP_CAPTURE;
            else if (se) op = TDR_OP_SHIFT;
            else if (ue) op = TDR_OP_UPDATE;
        end
        return op;
    endfunction

endpackage

// File: rtl/firebird7_in_gate1_tessent_tdr_shift_chain.sv
// Capture/shift register of the TDR; scan out is taken straight from bit 0,
// so there is never a combinational path from scan in to scan out.
module firebird7_in_gate1_tessent_tdr_shift_chain
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int LEN = TDR_W19_WIDTH + 1
) (
    input  logic           ijtag_tck,
    input  logic           ijtag_reset,
    input  logic           ijtag_sel,
    input  logic           ijtag_ce,
    input  logic           ijtag_se,
    input  logic           ijtag_si,
    input  logic [LEN-1:0] capture_vec,
    output logic [LEN-1:0] sr,
    output logic           ijtag_so
);

    tdr_op_e op;
    assign op = tdr_decode(ijtag_sel, ijtag_ce, ijtag_se, 1'b0);

    // Capture loads the whole chain; shift moves toward bit 0; otherwise hold.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            sr <= '0;
        end else begin
            case (op)
                TDR_OP_CAPTURE: sr <= capture_vec;
                TDR_OP_SHIFT:   sr <= {ijtag_si, sr[LEN-1:1]};
                default:        sr <= sr;
            endcase
        end
    end

    assign ijtag_so = sr[0];

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_w19_ctrl.sv
// IJTAG TDR steering the 19-bit functional/IJTAG data mux: captures the
// functional data, shifts through the SIB chain, updates the shadow data and
// select bit. Define FIREBIRD7_IN_GATE1_TDR_PARITY_EN to add an even-parity
// bit that gates updates and drives a sticky parity_err.
module firebird7_in_gate1_tessent_tdr_w19_ctrl
    import firebird7_in_gate1_tessent_tdr_pkg::*;
#(
    parameter int               WIDTH       = TDR_W19_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             ijtag_tck,
    input  logic             ijtag_reset,
    input  logic             ijtag_sel,
    input  logic             ijtag_ce,
    input  logic             ijtag_se,
    input  logic             ijtag_ue,
    input  logic             ijtag_si,
    output logic             ijtag_so,
    input  logic [WIDTH-1:0] capture_data_in,
    output logic [WIDTH-1:0] ijtag_data_out,
    output logic             ijtag_select_out,
    output logic             parity_err
);

    localparam int L = tdr_chain_len(WIDTH, TDR_PARITY_EN);

    logic [L-1:0] sr;
    logic [L-1:0] capture_vec;
    logic         do_update;

    assign do_update = (tdr_decode(ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue) == TDR_OP_UPDATE);

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    logic [TDR_PAR_MAX_W-1:0] par_src;
    logic                     perr_q;

    // Capture carries a freshly computed parity so an update straight after
    // a capture is always consistent.
    assign par_src     = TDR_PAR_MAX_W'({ijtag_select_out, capture_data_in});
    assign capture_vec = {tdr_even_parity(par_src), ijtag_select_out, capture_data_in};

    // Update only when the whole chain XORs to zero; otherwise hold and flag.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            ijtag_data_out   <= RESET_VALUE;
            ijtag_select_out <= 1'b0;
            perr_q           <= 1'b0;
        end else if (do_update) begin
            if (^sr == 1'b0) begin
                ijtag_data_out   <= sr[WIDTH-1:0];
                ijtag_select_out <= sr[WIDTH];
                perr_q           <= 1'b0;
            end else begin
                perr_q           <= 1'b1;
            end
        end
    end

    assign parity_err = perr_q;
`else
    assign capture_vec = {ijtag_select_out, capture_data_in};

    // Every qualified update is accepted.
    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            ijtag_data_out   <= RESET_VALUE;
            ijtag_select_out <= 1'b0;
        end else if (do_update) begin
            ijtag_data_out   <= sr[WIDTH-1:0];
            ijtag_select_out <= sr[WIDTH];
        end
    end

    assign parity_err = 1'b0;
`endif

    firebird7_in_gate1_tessent_tdr_shift_chain #(
        .LEN (L)
    ) u_chain (
        .ijtag_tck   (ijtag_tck),
        .ijtag_reset (ijtag_reset),
        .ijtag_sel   (ijtag_sel),
        .ijtag_ce    (ijtag_ce),
        .ijtag_se    (ijtag_se),
        .ijtag_si    (ijtag_si),
        .capture_vec (capture_vec),
        .sr          (sr),
        .ijtag_so    (ijtag_so)
    );

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_w19_ctrl.sv
// Scoreboard bench: stimulus pushes timestamped expectations, a negedge
// monitor pops and compares them. Honours FIREBIRD7_IN_GATE1_TDR_PARITY_EN.
module tb_firebird7_in_gate1_tessent_tdr_w19_ctrl;

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
    localparam int L = 21;
`else
    localparam int L = 20;
`endif

    localparam logic [3:0] M_D = 4'b0001, M_S = 4'b0010, M_SO = 4'b0100, M_PE = 4'b1000;
    localparam logic [3:0] M_ALL = 4'b1111;

    typedef struct {
        int          at;
        string       name;
        logic [18:0] d;
        logic        s;
        logic        so;
        logic        pe;
        logic [3:0]  mask;
    } exp_t;

    logic        tck = 1'b0;
    logic        rst, sel, ce, se, ue, si;
    logic [18:0] cap;
    logic        so, sel_out, perr;
    logic [18:0] dout;

    exp_t q[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    firebird7_in_gate1_tessent_tdr_w19_ctrl dut (
        .ijtag_tck        (tck),
        .ijtag_reset      (rst),
        .ijtag_sel        (sel),
        .ijtag_ce         (ce),
        .ijtag_se         (se),
        .ijtag_ue         (ue),
        .ijtag_si         (si),
        .ijtag_so         (so),
        .capture_data_in  (cap),
        .ijtag_data_out   (dout),
        .ijtag_select_out (sel_out),
        .parity_err       (perr)
    );

    always #5 tck = ~tck;
    always @(posedge tck) cyc <= cyc + 1;

    // Monitor: compare every expectation due at this cycle.
    always @(negedge tck) begin
        while (q.size() != 0 && q[0].at <= cyc) begin
            exp_t e;
            logic bad;
            e = q.pop_front();
            checks = checks + 1;
            bad = (e.at != cyc);
            if (e.mask[0] && dout    !== e.d)  bad = 1'b1;
            if (e.mask[1] && sel_out !== e.s)  bad = 1'b1;
            if (e.mask[2] && so      !== e.so) bad = 1'b1;
            if (e.mask[3] && perr    !== e.pe) bad = 1'b1;
            if (bad) begin
                errors = errors + 1;
                $display("FAIL %s @%0d(due %0d): got d=%h s=%b so=%b pe=%b, want d=%h s=%b so=%b pe=%b mask=%b",
                         e.name, cyc, e.at, dout, sel_out, so, perr, e.d, e.s, e.so, e.pe, e.mask);
            end
        end
    end

    // Expectation for the cycle after the current drive.
    function automatic void expect_next(string nm, logic [18:0] d, logic s, logic o,
                                        logic pe, logic [3:0] m);
        exp_t e;
        e.at = cyc + 1; e.name = nm; e.d = d; e.s = s; e.so = o; e.pe = pe; e.mask = m;
        q.push_back(e);
    endfunction

    task automatic step(input logic r, input logic sl, input logic c, input logic s,
                        input logic u, input logic i);
        @(negedge tck);
        rst = r; sel = sl; ce = c; se = s; ue = u; si = i;
    endtask

    // Shift a full vector (optionally preceded by junk bits and interrupted by
    // a 5-cycle deselect), then update and expect the given outputs.
    task automatic load(input string nm, input logic [18:0] d, input logic s, input bit bad_par,
                        input int pre, input int pause_at,
                        input logic [18:0] ed, input logic es, input logic epe);
        logic [L-1:0] v;
`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
        v = {(^{s, d}) ^ bad_par, s, d};
`else
        v = {s, d};
`endif
        for (int k = 0; k < pre; k++) step(0, 1, 0, 1, 0, 1);
        for (int k = 0; k < L; k++) begin
            if (k == pause_at)
                for (int p = 0; p < 5; p++) step(0, 0, 1, 1, 1, ~v[k]);
            step(0, 1, 0, 1, 0, v[k]);
        end
        step(0, 1, 0, 0, 1, 0);
        expect_next(nm, ed, es, 1'b0, epe, M_D | M_S | M_PE);
    endtask

    initial begin
        rst = 1; sel = 0; ce = 0; se = 0; ue = 0; si = 0; cap = '0;

        // Reset then idle.
        step(1, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0);
        expect_next("reset_idle", 19'h0, 1'b0, 1'b0, 1'b0, M_ALL);

        // Full load of 5A5A5 with select=1.
        load("load_5a5a5", 19'h5A5A5, 1'b1, 0, 0, -1, 19'h5A5A5, 1'b1, 1'b0);

        // Capture all ones, shift out 19 ones then current select (1).
        cap = 19'h7FFFF;
        step(0, 1, 1, 0, 0, 0);
        expect_next("cap_ones_bit0", 19'h5A5A5, 1'b1, 1'b1, 1'b0, M_D | M_S | M_SO);
        for (int k = 1; k <= 18; k++) begin
            step(0, 1, 0, 1, 0, 0);
            expect_next($sformatf("cap_ones_bit%0d", k), 19'h0, 1'b0, 1'b1, 1'b0, M_SO);
        end
        step(0, 1, 0, 1, 0, 0);
        expect_next("cap_sel_bit_one", 19'h0, 1'b0, 1'b1, 1'b0, M_SO);
        step(0, 1, 0, 1, 0, 0);
        expect_next("cap_bit20_zero", 19'h0, 1'b0, 1'b0, 1'b0, M_SO);

        // ce with ue: capture wins, outputs unchanged.
        cap = 19'h00F0F;
        step(0, 1, 1, 0, 1, 0);
        expect_next("ce_beats_ue", 19'h5A5A5, 1'b1, 1'b1, 1'b0, M_ALL);
        // Update without shifting rewrites the captured value.
        step(0, 1, 0, 0, 1, 0);
        expect_next("update_captured", 19'h00F0F, 1'b1, 1'b1, 1'b0, M_ALL);

        // Reset together with se: reset wins.
        cap = 19'h7FFFF;
        step(0, 1, 1, 0, 0, 0);
        step(1, 1, 0, 1, 0, 1);
        expect_next("reset_beats_se", 19'h0, 1'b0, 1'b0, 1'b0, M_ALL);
        step(0, 1, 0, 0, 1, 0);
        expect_next("update_after_reset", 19'h0, 1'b0, 1'b0, 1'b0, M_ALL);

        // New select=0 is what the next capture reads back.
        load("load_sel0", 19'h00010, 1'b0, 0, 0, -1, 19'h00010, 1'b0, 1'b0);
        cap = 19'h7FFFF;
        step(0, 1, 1, 0, 0, 0);
        for (int k = 1; k <= 18; k++) step(0, 1, 0, 1, 0, 0);
        expect_next("recap_bit18_one", 19'h0, 1'b0, 1'b1, 1'b0, M_SO);
        step(0, 1, 0, 1, 0, 0);
        expect_next("recap_sel_zero", 19'h00010, 1'b0, 1'b0, 1'b0, M_D | M_SO);

        // Deselect for 5 cycles mid-shift.
        load("sel_pause_12345", 19'h12345, 1'b1, 0, 0, 10, 19'h12345, 1'b1, 1'b0);

        // Overflow: 5 junk bits shifted out before the real vector.
        load("overflow_3c3c3", 19'h3C3C3, 1'b0, 0, 5, -1, 19'h3C3C3, 1'b0, 1'b0);

`ifdef FIREBIRD7_IN_GATE1_TDR_PARITY_EN
        load("bad_parity_held", 19'h00001, 1'b0, 1, 0, -1, 19'h3C3C3, 1'b0, 1'b1);
        load("good_parity_clr", 19'h00001, 1'b0, 0, 0, -1, 19'h00001, 1'b0, 1'b0);
`else
        load("no_parity_load", 19'h00001, 1'b0, 1, 0, -1, 19'h00001, 1'b0, 1'b0);
`endif

        step(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge tck);
        if (q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL pending: %0d expectations never checked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
